ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_if.sv | 43 ++++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared encodings for the byte-wide RAM/IO arbiter
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ArbIdle   = 3'd0,
        ArbInstRd = 3'd1,
        ArbDataRd = 3'd2,
        ArbDataWr = 3'd3,
        ArbDone   = 3'd4
    } arb_state_e;

    localparam logic [2:0] Len1 = 3'd1;
    localparam logic [2:0] Len2 = 3'd2;
    localparam logic [2:0] Len4 = 3'd4;
    localparam logic [1:0] IoHi = 2'b11;

    // Any length code other than 1 or 2 moves a full word.
    function automatic logic [2:0] len_bytes(input logic [2:0] len);
        case (len)
            Len1:    return Len1;
            Len2:    return Len2;
            default: return Len4;
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-port signals of the arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid;
    logic [31:0]       inst_data;
    logic              inst_busy;

    logic              data_req;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [2:0]        data_len;
    logic [31:0]       data_wdata;
    logic              data_valid;
    logic [31:0]       data_rdata;
    logic              data_busy;

    logic              io_buffer_full;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output inst_req, inst_addr,
        input  inst_valid, inst_data, inst_busy,
        output data_req, data_wr, data_addr, data_len, data_wdata,
        input  data_valid, data_rdata, data_busy,
        output io_buffer_full, ram_din,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_valid, inst_data, inst_busy,
        input  data_req, data_wr, data_addr, data_len, data_wdata,
        output data_valid, data_rdata, data_busy,
        input  io_buffer_full, ram_din,
        output ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serialises icache fetches and mem-stage loads/stores onto the byte RAM port
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IoHi
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    ram_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_n;
    logic [2:0]        cnt_q, cnt_n;
    logic [2:0]        num_q, num_n;
    logic [ADDR_W-1:0] a_q, a_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [31:0]       rbuf_q, rbuf_n;
    logic              from_data_q, from_data_n;
    logic              rdy_q;
    logic [7:0]        din_hold;
    logic [7:0]        din_eff;
    logic [7:0]        dout_byte;
    logic              io_stall;
    logic              wr_issue;
    logic              inst_pulse;
    logic              data_pulse;

    // The RAM keeps clocking while rdy is low, so the byte returned for the
    // last pre-pause address is parked and used on the first resumed cycle.
    assign din_eff  = rdy_q ? bus.ram_din : din_hold;
    assign io_stall = (a_q[17:16] == IO_HI) && bus.io_buffer_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            cnt_q       <= 3'd0;
            num_q       <= 3'd0;
            a_q         <= '0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            from_data_q <= 1'b0;
            rdy_q       <= 1'b1;
            din_hold    <= 8'd0;
        end else begin
            rdy_q <= rdy;
            if (!rdy && rdy_q) begin
                din_hold <= bus.ram_din;
            end
            if (rdy) begin
                state_q     <= state_n;
                cnt_q       <= cnt_n;
                num_q       <= num_n;
                a_q         <= a_n;
                wdata_q     <= wdata_n;
                rbuf_q      <= rbuf_n;
                from_data_q <= from_data_n;
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        num_n       = num_q;
        a_n         = a_q;
        wdata_n     = wdata_q;
        rbuf_n      = rbuf_q;
        from_data_n = from_data_q;
        wr_issue    = 1'b0;
        inst_pulse  = 1'b0;
        data_pulse  = 1'b0;
        case (state_q)
            ArbIdle: begin
                if (bus.data_req) begin
                    state_n     = bus.data_wr ? ArbDataWr : ArbDataRd;
                    from_data_n = 1'b1;
                    a_n         = bus.data_addr;
                    num_n       = len_bytes(bus.data_len);
                    wdata_n     = bus.data_wdata;
                    rbuf_n      = 32'd0;
                    cnt_n       = 3'd0;
                end else if (bus.inst_req && !flush) begin
                    state_n     = ArbInstRd;
                    from_data_n = 1'b0;
                    a_n         = bus.inst_addr;
                    num_n       = Len4;
                    rbuf_n      = 32'd0;
                    cnt_n       = 3'd0;
                end
            end
            ArbInstRd, ArbDataRd: begin
                if (state_q == ArbInstRd && flush) begin
                    state_n = ArbIdle;
                    cnt_n   = 3'd0;
                end else begin
                    // cnt counts issued addresses; byte cnt-1 arrives now.
                    case (cnt_q)
                        3'd1:    rbuf_n[7:0]   = din_eff;
                        3'd2:    rbuf_n[15:8]  = din_eff;
                        3'd3:    rbuf_n[23:16] = din_eff;
                        3'd4:    rbuf_n[31:24] = din_eff;
                        default: ;
                    endcase
                    if (cnt_q == num_q) begin
                        state_n = ArbDone;
                        cnt_n   = 3'd0;
                    end else begin
                        cnt_n = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 != num_q) begin
                            a_n = a_q + ADDR_W'(1);
                        end
                    end
                end
            end
            ArbDataWr: begin
                if (!io_stall) begin
                    wr_issue = 1'b1;
                    if (cnt_q + 3'd1 == num_q) begin
                        state_n = ArbDone;
                        cnt_n   = 3'd0;
                    end else begin
                        cnt_n = cnt_q + 3'd1;
                        a_n   = a_q + ADDR_W'(1);
                    end
                end
            end
            ArbDone: begin
                state_n    = ArbIdle;
                data_pulse = from_data_q;
                inst_pulse = !from_data_q && !flush;
            end
            default: state_n = ArbIdle;
        endcase
    end

    always_comb begin
        dout_byte = wdata_q[7:0];
        case (cnt_q)
            3'd1:    dout_byte = wdata_q[15:8];
            3'd2:    dout_byte = wdata_q[23:16];
            3'd3:    dout_byte = wdata_q[31:24];
            default: ;
        endcase
    end

    assign bus.ram_wr     = wr_issue && rdy;
    assign bus.ram_a      = a_q;
    assign bus.ram_dout   = dout_byte;
    assign bus.inst_valid = inst_pulse;
    assign bus.data_valid = data_pulse;
    assign bus.inst_data  = rbuf_q;
    assign bus.data_rdata = rbuf_q;
    assign bus.inst_busy  = (state_q == ArbDataRd) || (state_q == ArbDataWr) ||
                            ((state_q == ArbDone) && from_data_q);
    assign bus.data_busy  = (state_q == ArbInstRd) ||
                            ((state_q == ArbDone) && !from_data_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        logic        is_inst;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        is_inst;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic flush = 1'b0;

    ram_arbiter_if #(.ADDR_W(32)) bus ();

    ram_arbiter #(.ADDR_W(32), .IO_HI(IoHi)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:262143];
    logic        poke_en = 1'b0;
    logic [17:0] poke_addr = 18'd0;
    logic [7:0]  poke_data = 8'd0;

    always @(posedge clk) begin
        bus.ram_din <= mem[bus.ram_a[17:0]];
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.ram_wr) mem[bus.ram_a[17:0]] <= bus.ram_dout;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   last_pulse_cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] mon_got;
    vec_t vecs[12];

    always @(negedge clk) begin
        if (!rst && (bus.inst_valid || bus.data_valid)) begin
            pulses++;
            last_pulse_cyc = cyc;
            checks++;
            mon_got = bus.inst_valid ? bus.inst_data : bus.data_rdata;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: inst_valid=%0b data_valid=%0b data=%h, required no pulse",
                         bus.inst_valid, bus.data_valid, mon_got);
            end else begin
                mon_e = sb.pop_front();
                if ((bus.inst_valid && bus.data_valid) || (bus.inst_valid != mon_e.is_inst) ||
                    (mon_e.chk_data && (mon_got !== mon_e.data))) begin
                    errors++;
                    $display("FAIL sb_pulse: inst_valid=%0b data_valid=%0b data=%h, required inst=%0b data=%h",
                             bus.inst_valid, bus.data_valid, mon_got, mon_e.is_inst, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [17:0] addr, input logic [7:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        drive_edge();
        poke_en = 1'b0;
    endtask

    task automatic wait_pulse(input int start_p, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (pulses != start_p) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no valid pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic idle_outputs(input string name);
        check({name, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
        check({name, "_valid"}, {30'd0, bus.inst_valid, bus.data_valid}, 32'd0);
        check({name, "_busy"}, {30'd0, bus.inst_busy, bus.data_busy}, 32'd0);
        check({name, "_ram_a"}, bus.ram_a, 32'd0);
        check({name, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
        check({name, "_rdata"}, bus.data_rdata, 32'd0);
        check({name, "_idata"}, bus.inst_data, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int cyc_a;
        int p;
        drive_edge();
        sb.push_back('{v.is_inst, v.is_inst || !v.wr, v.exp_data});
        if (v.is_inst) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = v.addr;
        end else begin
            bus.data_req   = 1'b1;
            bus.data_wr    = v.wr;
            bus.data_addr  = v.addr;
            bus.data_len   = v.len;
            bus.data_wdata = v.wdata;
        end
        cyc_a = cyc;
        p     = pulses;
        wait_pulse(p, 40, name);
        check({name, "_lat"}, 32'(last_pulse_cyc - cyc_a), 32'(v.exp_lat));
        drive_edge();
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc_a;
        int p;

        vecs[0]  = '{1'b0, 1'b1, 32'h500, 3'd4, 32'hDEADBEEF, 32'h0, 5};
        vecs[1]  = '{1'b0, 1'b1, 32'h510, 3'd2, 32'h1234CAFE, 32'h0, 3};
        vecs[2]  = '{1'b0, 1'b1, 32'h520, 3'd1, 32'h000000A5, 32'h0, 2};
        vecs[3]  = '{1'b0, 1'b1, 32'h530, 3'd0, 32'h01020304, 32'h0, 5};
        vecs[4]  = '{1'b0, 1'b0, 32'h500, 3'd4, 32'h0, 32'hDEADBEEF, 6};
        vecs[5]  = '{1'b0, 1'b0, 32'h500, 3'd2, 32'h0, 32'h0000BEEF, 4};
        vecs[6]  = '{1'b0, 1'b0, 32'h503, 3'd1, 32'h0, 32'h000000DE, 3};
        vecs[7]  = '{1'b0, 1'b0, 32'h510, 3'd4, 32'h0, 32'h0000CAFE, 6};
        vecs[8]  = '{1'b0, 1'b0, 32'h520, 3'd1, 32'h0, 32'h000000A5, 3};
        vecs[9]  = '{1'b0, 1'b0, 32'h530, 3'd7, 32'h0, 32'h01020304, 6};
        vecs[10] = '{1'b1, 1'b0, 32'h500, 3'd0, 32'h0, 32'hDEADBEEF, 6};
        vecs[11] = '{1'b0, 1'b0, 32'h500, 3'd3, 32'h0, 32'hDEADBEEF, 6};

        bus.inst_req       = 1'b0;
        bus.inst_addr      = 32'd0;
        bus.data_req       = 1'b0;
        bus.data_wr        = 1'b0;
        bus.data_addr      = 32'd0;
        bus.data_len       = 3'd0;
        bus.data_wdata     = 32'd0;
        bus.io_buffer_full = 1'b0;

        drive_edge();
        poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h00); poke(18'h103, 8'h00);
        poke(18'h104, 8'h37); poke(18'h105, 8'h01); poke(18'h106, 8'h00); poke(18'h107, 8'h10);
        poke(18'h040, 8'h93); poke(18'h041, 8'h00); poke(18'h042, 8'h10); poke(18'h043, 8'h00);
        poke(18'h080, 8'hAA); poke(18'h081, 8'hBB); poke(18'h082, 8'hCC); poke(18'h083, 8'hDD);
        poke(18'h300, 8'h11); poke(18'h301, 8'h22); poke(18'h302, 8'h33); poke(18'h303, 8'h44);
        poke(18'h202, 8'h77); poke(18'h403, 8'hEE); poke(18'h512, 8'h00); poke(18'h513, 8'h00);

        @(negedge clk);
        idle_outputs("reset");
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", {30'd0, bus.inst_busy, bus.data_busy}, 32'd0);

        // 4-byte fetch: address walk and acceptance-to-valid latency.
        drive_edge();
        sb.push_back('{1'b1, 1'b1, 32'h00000513});
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h100;
        cyc_a = cyc;
        p     = pulses;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("fetch_ram_a_%0d", k), bus.ram_a, 32'h100 + 32'(k - 1));
            if (k == 1) check("fetch_data_busy", 32'(bus.data_busy), 32'd1);
        end
        wait_pulse(p, 10, "fetch");
        check("fetch_lat", 32'(last_pulse_cyc - cyc_a), 32'd6);
        drive_edge();
        bus.inst_req = 1'b0;

        // Simultaneous requests: data wins, fetch follows after the gap.
        drive_edge();
        sb.push_back('{1'b0, 1'b0, 32'h0});
        sb.push_back('{1'b1, 1'b1, 32'h10000137});
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h104;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_addr  = 32'h200;
        bus.data_len   = 3'd2;
        bus.data_wdata = 32'hAABBCCDD;
        cyc_a = cyc;
        p     = pulses;
        @(negedge clk);
        @(negedge clk);
        check("both_wr0", {bus.ram_a[23:0], bus.ram_dout}, {24'h000200, 8'hDD});
        check("both_wr0_en", {30'd0, bus.ram_wr, bus.inst_busy}, 32'd3);
        @(negedge clk);
        check("both_wr1", {bus.ram_a[23:0], bus.ram_dout}, {24'h000201, 8'hCC});
        check("both_wr1_en", {30'd0, bus.ram_wr, bus.inst_busy}, 32'd3);
        @(negedge clk);
        check("both_done_busy", 32'(bus.inst_busy), 32'd1);
        drive_edge();
        bus.data_req = 1'b0;
        @(negedge clk);
        check("both_gap", {30'd0, bus.inst_busy, bus.data_busy}, 32'd0);
        @(negedge clk);
        check("both_inst_start", {bus.ram_a[30:0], bus.data_busy}, {31'h104, 1'b1});
        wait_pulse(p + 1, 12, "both_inst");
        check("both_inst_lat", 32'(last_pulse_cyc - cyc_a), 32'd10);
        drive_edge();
        bus.inst_req = 1'b0;
        check("both_mem", {8'd0, mem[18'h200], mem[18'h201], mem[18'h202]}, 32'h00DDCC77);

        // IO store held off by a full UART buffer.
        drive_edge();
        sb.push_back('{1'b0, 1'b0, 32'h0});
        bus.io_buffer_full = 1'b1;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_addr  = 32'h30000;
        bus.data_len   = 3'd1;
        bus.data_wdata = 32'h00000041;
        cyc_a = cyc;
        p     = pulses;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("io_stall_%0d", k), 32'(bus.ram_wr), 32'd0);
        end
        drive_edge();
        bus.io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_write", {bus.ram_wr, bus.ram_a[22:0], bus.ram_dout}, {1'b1, 23'h30000, 8'h41});
        wait_pulse(p, 10, "io");
        check("io_lat", 32'(last_pulse_cyc - cyc_a), 32'd5);
        drive_edge();
        bus.data_req = 1'b0;
        repeat (3) @(negedge clk);
        check("io_one_pulse", 32'(pulses - p), 32'd1);
        check("io_mem", 32'(mem[18'h30000]), 32'h41);

        // Flush on the second issue cycle of a fetch, then a fresh fetch.
        drive_edge();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h80;
        drive_edge();
        drive_edge();
        flush = 1'b1;
        @(negedge clk);
        check("flush_issue_a", bus.ram_a, 32'h81);
        drive_edge();
        flush = 1'b0;
        bus.inst_addr = 32'h40;
        sb.push_back('{1'b1, 1'b1, 32'h00100093});
        cyc_a = cyc;
        p     = pulses;
        @(negedge clk);
        check("flush_idle", {30'd0, bus.inst_busy, bus.data_busy}, 32'd0);
        wait_pulse(p, 12, "flush_refetch");
        check("flush_refetch_lat", 32'(last_pulse_cyc - cyc_a), 32'd6);
        drive_edge();
        bus.inst_req = 1'b0;

        // Load paused by rdy for two cycles mid-transfer.
        drive_edge();
        sb.push_back('{1'b0, 1'b1, 32'h44332211});
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = 32'h300;
        bus.data_len  = 3'd4;
        cyc_a = cyc;
        p     = pulses;
        drive_edge();
        drive_edge();
        rdy = 1'b0;
        @(negedge clk);
        check("pause_a_0", {bus.ram_a[30:0], bus.ram_wr}, {31'h301, 1'b0});
        drive_edge();
        @(negedge clk);
        check("pause_a_1", {bus.ram_a[30:0], bus.ram_wr}, {31'h301, 1'b0});
        drive_edge();
        rdy = 1'b1;
        wait_pulse(p, 14, "pause");
        check("pause_lat", 32'(last_pulse_cyc - cyc_a), 32'd8);
        drive_edge();
        bus.data_req = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed in the middle of a 4-byte store.
        drive_edge();
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_addr  = 32'h400;
        bus.data_len   = 3'd4;
        bus.data_wdata = 32'h11223344;
        p = pulses;
        drive_edge();
        drive_edge();
        drive_edge();
        rst = 1'b1;
        bus.data_req = 1'b0;
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        idle_outputs("rst_mid");
        repeat (5) @(negedge clk);
        check("rst_mid_no_pulse", 32'(pulses - p), 32'd0);
        check("rst_mid_mem", {8'd0, mem[18'h400], mem[18'h401], mem[18'h403]}, 32'h004433EE);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
